// File: rtl/route_compute_arbiter.sv
// Shares one route_compute instance among NUM_REQ input ports using an IDLE/COMPUTE/RESULT handshake.
// Define ROUTE_ARB_RR_EN for round-robin arbitration; when it is left undefined, fixed priority is used (lowest index wins).
module route_compute_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int NUM_OUTPORTS = 4,
    parameter int FLIT_W       = 32,
    localparam int SELECT_SIZE = $clog2(NUM_OUTPORTS) + ((NUM_OUTPORTS == 1) ? 1 : 0),
    localparam int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                              clk,
    input  logic                              n_rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0][FLIT_W-1:0]    req_flit,
    output logic [NUM_REQ-1:0]                req_done,
    output logic [SELECT_SIZE-1:0]            req_out_sel,
    output logic                              rc_valid,
    output logic [FLIT_W-1:0]                 rc_head_flit,
    input  logic [SELECT_SIZE-1:0]            rc_out_sel,
    output logic                              busy
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_RESULT  = 2'd2;

    logic [1:0]         r_state;
    logic [IDX_W-1:0]   r_grant_idx;
    logic [FLIT_W-1:0]  r_flit_q;

    logic [NUM_REQ-1:0] w_mask;
    logic [IDX_W-1:0]   w_scan_ptr;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_win_found;

    // Returns {found, index} of the first set mask bit at or after ptr, wrapping modulo NUM_REQ.
    function automatic logic [IDX_W:0] arbitrate(input logic [NUM_REQ-1:0] mask,
                                                 input logic [IDX_W-1:0]   ptr);
        logic             found;
        logic [IDX_W-1:0] idx;
        int               pos;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = (int'(ptr) + k) % NUM_REQ;
            if (!found && mask[pos[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = pos[IDX_W-1:0];
            end
        end
        return {found, idx};
    endfunction

`ifdef ROUTE_ARB_RR_EN
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_next_ptr;

    assign w_next_ptr = (r_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_idx + 1'b1;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rr_ptr <= '0;
        end else if (r_state == S_RESULT) begin
            r_rr_ptr <= w_next_ptr;
        end
    end

    // Back-to-back arbitration in RESULT must already see the advanced pointer.
    assign w_scan_ptr = (r_state == S_RESULT) ? w_next_ptr : r_rr_ptr;
`else
    assign w_scan_ptr = '0;
`endif

    always_comb begin
        w_mask = '0;
        if (r_state == S_IDLE) begin
            w_mask = req_valid;
        end else if (r_state == S_RESULT) begin
            w_mask = req_valid & ~(NUM_REQ'(1) << r_grant_idx);
        end
    end

    assign {w_win_found, w_win_idx} = arbitrate(w_mask, w_scan_ptr);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= S_IDLE;
            r_grant_idx <= '0;
            r_flit_q    <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_RESULT: begin
                    if (w_win_found) begin
                        r_state     <= S_COMPUTE;
                        r_grant_idx <= w_win_idx;
                        r_flit_q    <= req_flit[w_win_idx];
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_COMPUTE: r_state <= S_RESULT;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_done
            assign req_done[gi] = (r_state == S_RESULT) && (r_grant_idx == IDX_W'(gi));
        end
    endgenerate

    assign req_out_sel  = (r_state == S_RESULT) ? rc_out_sel : '0;
    assign rc_valid     = (r_state == S_COMPUTE);
    assign rc_head_flit = r_flit_q;
    assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_route_compute_arbiter.sv
// Randomized and directed bench for route_compute_arbiter against a transaction-level reference model.
module tb_route_compute_arbiter;

    localparam int NREQ = 4;
    localparam int NOUT = 4;
    localparam int FW   = 16;
    localparam int SEL  = 2;

    logic                      clk = 1'b0;
    logic                      n_rst;
    logic [NREQ-1:0]           req_valid;
    logic [NREQ-1:0][FW-1:0]   req_flit;
    logic [NREQ-1:0]           req_done;
    logic [SEL-1:0]            req_out_sel;
    logic                      rc_valid;
    logic [FW-1:0]             rc_head_flit;
    logic [SEL-1:0]            rc_out_sel = '0;
    logic                      busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: which port is in flight and how many cycles since its grant.
    int             m_port = -1;
    int             m_age  = 0;
    int             m_ptr  = 0;
    logic [FW-1:0]  m_flit = '0;

    int done_port[$];
    int done_cyc[$];

    always #5 clk = ~clk;

    route_compute_arbiter #(
        .NUM_REQ      (NREQ),
        .NUM_OUTPORTS (NOUT),
        .FLIT_W       (FW)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .req_valid    (req_valid),
        .req_flit     (req_flit),
        .req_done     (req_done),
        .req_out_sel  (req_out_sel),
        .rc_valid     (rc_valid),
        .rc_head_flit (rc_head_flit),
        .rc_out_sel   (rc_out_sel),
        .busy         (busy)
    );

    // Destination in the low nibble; LUT maps dest 3 -> 2, dest 5 -> 0.
    function automatic logic [SEL-1:0] lut(input logic [FW-1:0] f);
        return SEL'((int'(f[3:0]) + 3) % NOUT);
    endfunction

    // Stand-in for route_compute: registers its result on a valid cycle.
    always @(posedge clk) begin
        if (rc_valid) rc_out_sel <= lut(rc_head_flit);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_port = -1;
        m_age  = 0;
        m_ptr  = 0;
        m_flit = '0;
    endtask

    task automatic model_step();
        logic [NREQ-1:0] cand;
        int start;
        int w;
        if (m_port < 0 || m_age == 2) begin
            cand  = req_valid;
            start = 0;
            if (m_port >= 0) begin
                cand[m_port] = 1'b0;
`ifdef ROUTE_ARB_RR_EN
                m_ptr = (m_port + 1) % NREQ;
`endif
            end
`ifdef ROUTE_ARB_RR_EN
            start = m_ptr;
`endif
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (w < 0 && cand[(start + k) % NREQ]) w = (start + k) % NREQ;
            end
            if (w >= 0) begin
                m_port = w;
                m_age  = 1;
                m_flit = req_flit[w];
            end else begin
                m_port = -1;
                m_age  = 0;
            end
        end else begin
            m_age = 2;
        end
    endtask

    task automatic compare();
        logic [NREQ-1:0] exp_done;
        exp_done = '0;
        if (m_age == 2) exp_done[m_port] = 1'b1;
        check_val("busy", 32'(busy), 32'(m_port >= 0));
        check_val("rc_valid", 32'(rc_valid), 32'(m_port >= 0 && m_age == 1));
        check_val("rc_head_flit", 32'(rc_head_flit), 32'(m_flit));
        check_val("req_done", 32'(req_done), 32'(exp_done));
        check_val("req_out_sel", 32'(req_out_sel), (m_age == 2) ? 32'(lut(m_flit)) : 32'd0);
    endtask

    task automatic drive(input logic [NREQ-1:0] v);
        @(negedge clk);
        req_valid = v;
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst     = 1'b0;
        req_valid = '0;
        #1;
        model_reset();
        compare();
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    // Holds requests in v0 until each port's done pulse, recording completion order and cycle.
    task automatic serve_all(input logic [NREQ-1:0] v0, input int budget);
        logic [NREQ-1:0] v;
        int c;
        v = v0;
        c = 0;
        done_port.delete();
        done_cyc.delete();
        while (c < budget && (v != '0 || busy)) begin
            drive(v);
            c++;
            for (int p = 0; p < NREQ; p++) begin
                if (req_done[p]) begin
                    done_port.push_back(p);
                    done_cyc.push_back(c);
                end
            end
            v &= ~req_done;
        end
        check_val("serve_timeout", 32'(v), 32'd0);
    endtask

    task automatic expect_done(input string tag, input int idx, input int port, input int cyc);
        if (idx < done_port.size()) begin
            check_val($sformatf("%s_port%0d", tag, idx), 32'(done_port[idx]), 32'(port));
            check_val($sformatf("%s_cyc%0d", tag, idx), 32'(done_cyc[idx]), 32'(cyc));
        end
    endtask

    initial begin
        logic [NREQ-1:0] act;
        logic [NREQ-1:0] cool;

        n_rst     = 1'b0;
        req_valid = '0;
        req_flit  = '0;
        #1;
        compare();
        @(negedge clk);
        n_rst = 1'b1;

        // Single request from port 1, dest 3.
        req_flit[1] = 16'h0003;
        serve_all(4'b0010, 10);
        check_val("t1_count", 32'(done_port.size()), 32'd1);
        expect_done("t1", 0, 1, 2);

        // All four ports contending.
        do_reset();
        for (int p = 0; p < NREQ; p++) req_flit[p] = FW'(p + 2);
        serve_all(4'b1111, 20);
        check_val("t2_count", 32'(done_port.size()), 32'd4);
        for (int i = 0; i < 4; i++) expect_done("t2", i, i, 2 + 2 * i);

        // Ports 0 and 2 contending.
        do_reset();
        serve_all(4'b0101, 12);
        check_val("t3_count", 32'(done_port.size()), 32'd2);
        expect_done("t3", 0, 0, 2);
        expect_done("t3", 1, 2, 4);

        // Wrap: a grant on port 2 leaves the pointer at 3, then ports 0 and 3 contend.
        do_reset();
        serve_all(4'b0100, 10);
        serve_all(4'b1001, 12);
        check_val("t4_count", 32'(done_port.size()), 32'd2);
`ifdef ROUTE_ARB_RR_EN
        expect_done("t4", 0, 3, 2);
        expect_done("t4", 1, 0, 4);
`else
        expect_done("t4", 0, 0, 2);
        expect_done("t4", 1, 3, 4);
`endif

        // Reset while in COMPUTE aborts the transaction.
        req_flit[0] = 16'h0003;
        drive(4'b0001);
        check_val("t5_rc_valid_pre", 32'(rc_valid), 32'd1);
        n_rst = 1'b0;
        #1;
        model_reset();
        compare();
        @(negedge clk);
        req_valid = '0;
        @(posedge clk);
        #1;
        compare();
        check_val("t5_no_done", 32'(req_done), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        req_flit[1] = 16'h0003;
        serve_all(4'b0010, 10);
        check_val("t5_count", 32'(done_port.size()), 32'd1);
        expect_done("t5", 0, 1, 2);

        // Flit changed on the cycle after grant must not affect the result.
        do_reset();
        req_flit[2] = 16'h0003;
        drive(4'b0100);
        req_flit[2] = 16'h0005;
        drive(4'b0100);
        check_val("t6_done", 32'(req_done), 32'h4);
        check_val("t6_out_sel", 32'(req_out_sel), 32'd2);
        drive(4'b0000);
        drive(4'b0000);

        // Randomized requesters: hold until done, then stay quiet for one cycle.
        act  = '0;
        cool = '0;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < NREQ; p++) begin
                if (!act[p] && !cool[p] && $urandom_range(0, 2) == 0) begin
                    act[p]      = 1'b1;
                    req_flit[p] = FW'($urandom);
                end
            end
            drive(act);
            cool = req_done;
            act &= ~req_done;
        end
        for (int c = 0; c < 20; c++) begin
            drive(act);
            act &= ~req_done;
        end
        check_val("rand_drain", 32'(act), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
